div3_ternary_serializer: RTL and testbench

DIV3_TERNARY_SERIALIZER -- requirements
Module: div3_ternary_serializer

---
 rtl/div3_ternary_serializer_pkg.sv | 14 +
 rtl/div3_ternary_serializer_div_32_3.sv | 34 +++
 rtl/div3_ternary_serializer.sv | 120 ++++++++++++
 tb/tb_div3_ternary_serializer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_ternary_serializer_pkg.sv
// Shared definitions for the ternary serializer.
//   N_DIGITS : base-3 digits needed to cover any 32-bit word (3^21 > 2^32-1)
//   IDX_W    : width of the digit position counter
//   state_e  : controller states
`timescale 1ns/1ps
package div3_ternary_serializer_pkg;
  localparam int N_DIGITS = 21;
  localparam int IDX_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/div3_ternary_serializer_div_32_3.sv
// div_32_3: combinational divide-by-3 of a 32-bit unsigned value.
// Ports:
//   dividend  [32:1] in  : value to divide (bit 32 is the MSB)
//   quotient  [30:0] out : floor(dividend / 3); fits in 31 bits
//   remainder [1:0]  out : dividend mod 3, always 0..2
// Restoring long division with a 2-bit partial remainder. The divisor
// is a constant, so each step is a compare against 3 and an optional
// subtract.
`timescale 1ns/1ps
module div_32_3 (
  input  logic [32:1] dividend,
  output logic [30:0] quotient,
  output logic [1:0]  remainder
);
  logic [1:0] rem;
  logic [2:0] part;

  always_comb begin
    quotient = '0;
    part     = '0;
    // The top bit alone is always below 3, so it seeds the remainder.
    rem      = {1'b0, dividend[32]};
    for (int i = 31; i >= 1; i--) begin
      part = {rem, dividend[i]};
      if (part >= 3'd3) begin
        quotient[i-1] = 1'b1;
        rem           = 2'(part - 3'd3);
      end else begin
        rem           = part[1:0];
      end
    end
    remainder = rem;
  end
endmodule

// File: rtl/div3_ternary_serializer.sv
// div3_ternary_serializer: converts a 32-bit unsigned word into base-3
// digits, emitted least-significant first over a valid/ready stream.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input word handshake
//   in_data  [31:0]      : word to convert
//   dig_valid/dig_ready  : digit handshake
//   dig_data [1:0]       : digit value 0..2
//   dig_idx  [4:0]       : digit position, 0 = least significant
//   dig_last             : final digit of the current word
// Build option: define TERN_ZERO_SUPPRESS_EN to stop a word as soon as
// the remaining quotient is zero (leading zeros suppressed, at least one
// digit emitted). Without it every word emits exactly N_DIGITS digits.
`timescale 1ns/1ps
module div3_ternary_serializer
  import div3_ternary_serializer_pkg::*;
#(
  parameter int N_DIGITS = div3_ternary_serializer_pkg::N_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [1:0]       dig_data,
  output logic [IDX_W-1:0] dig_idx,
  output logic             dig_last
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_e           state_q, state_d;
  logic [31:0]      w_q, w_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             dig_valid_q, dig_valid_d;

  logic [30:0]      quo;
  logic [1:0]       rem;
  logic             last_hit;

  // Single divider: its remainder is the digit on the bus, its quotient
  // is the work value for the next digit.
  div_32_3 u_div (
    .dividend  (w_q),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef TERN_ZERO_SUPPRESS_EN
  assign last_hit = (quo == 31'd0) || (idx_q == LAST_IDX);
`else
  assign last_hit = (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    dig_valid_d = dig_valid_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        dig_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          state_d     = RUN;
          w_d         = in_data;
          idx_d       = '0;
          in_ready_d  = 1'b0;
          dig_valid_d = 1'b1;
        end
      end
      RUN: begin
        // W and idx only move on a handshake, so the digit bus is stable
        // while the consumer stalls.
        if (dig_valid_q && dig_ready) begin
          if (last_hit) begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            dig_valid_d = 1'b0;
          end else begin
            w_d   = {1'b0, quo};
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        dig_valid_d = 1'b0;
      end
    endcase
  end

  // in_ready_q resets low so nothing is accepted while rst_n is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      dig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      dig_valid_q <= dig_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign dig_valid = dig_valid_q;
  // Gated so a stale work value in IDLE never shows on the digit bus.
  assign dig_data  = dig_valid_q ? rem : 2'd0;
  assign dig_idx   = idx_q;
  assign dig_last  = dig_valid_q && last_hit;
endmodule

// File: tb/tb_div3_ternary_serializer.sv
// Scoreboard bench for div3_ternary_serializer. Build option
// TERN_ZERO_SUPPRESS_EN selects the matching expected digit counts.
`timescale 1ns/1ps
module tb_div3_ternary_serializer;
  localparam int ND = 21;

  typedef logic [2*ND-1:0] dig_vec_t;
  typedef struct packed {
    logic [1:0] data;
    logic [4:0] idx;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        dig_valid;
  logic        dig_ready;
  logic [1:0]  dig_data;
  logic [4:0]  dig_idx;
  logic        dig_last;

  exp_t        exp_q[$];
  logic [31:0] word_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic        bb_mode = 1'b0;
  logic        keep_valid = 1'b0;

  // Hand-computed digit vectors, written most-significant digit first.
  localparam dig_vec_t D_FIVE = {38'd0, 2'd1, 2'd2};
  localparam dig_vec_t D_ZERO = '0;
  localparam dig_vec_t D_FF   = {30'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  localparam dig_vec_t D_MAX  = {2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0,
                                 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2,
                                 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0};

  div3_ternary_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .dig_idx   (dig_idx),
    .dig_last  (dig_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic dig_vec_t to_tern(input logic [31:0] w);
    dig_vec_t        r;
    longint unsigned v;
    r = '0;
    v = 64'(w);
    for (int k = 0; k < ND; k++) begin
      r[2*k +: 2] = 2'(v % 3);
      v = v / 3;
    end
    return r;
  endfunction

  task automatic push_word(input logic [31:0] w, input dig_vec_t d);
    int n;
`ifdef TERN_ZERO_SUPPRESS_EN
    n = 1;
    for (int k = 0; k < ND; k++)
      if (d[2*k +: 2] != 2'd0) n = k + 1;
`else
    n = ND;
`endif
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = d[2*k +: 2];
      e.idx  = 5'(k);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    word_q.push_back(w);
  endtask

  task automatic send(input logic [31:0] w, input dig_vec_t d);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1 for word 0x%08h", in_ready, w);
      in_valid = 1'b0;
    end else begin
      push_word(w, d);
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d digits outstanding expected 0", exp_q.size());
      exp_q.delete();
      word_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin : ready_gen
    int   stall_left;
    logic stalled;
    dig_ready  = 1'b1;
    stall_left = 0;
    stalled    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: dig_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stalled && dig_valid && dig_idx == 5'd2) begin
            stalled    = 1'b1;
            stall_left = 3;
          end
          if (stall_left > 0) begin
            dig_ready = 1'b0;
            stall_left--;
          end else begin
            dig_ready = 1'b1;
          end
        end
        default: begin
          dig_ready = 1'b1;
          stalled   = 1'b0;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every digit handshake.
  initial begin : monitor
    exp_t            e;
    longint unsigned acc;
    longint unsigned pw;
    logic            held_v;
    logic [8:0]      held;
    logic            armed;
    int              gap;
    acc    = 0;
    pw     = 1;
    held_v = 1'b0;
    held   = '0;
    armed  = 1'b0;
    gap    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc    = 0;
        pw     = 1;
        held_v = 1'b0;
        armed  = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_hold", 64'({dig_valid, dig_data, dig_idx, dig_last}), 64'(held));
          held_v = 1'b0;
        end
        if (dig_valid && !dig_ready) begin
          held_v = 1'b1;
          held   = {dig_valid, dig_data, dig_idx, dig_last};
        end
        if (armed) begin
          if (dig_valid) begin
            check("bubble", 64'(gap), 64'd1);
            armed = 1'b0;
          end else begin
            gap++;
          end
        end
        if (dig_valid && dig_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_digit: data=%0d idx=%0d last=%0b, none expected",
                     dig_data, dig_idx, dig_last);
          end else begin
            e = exp_q.pop_front();
            check("digit", 64'({dig_data, dig_idx, dig_last}), 64'({e.data, e.idx, e.last}));
          end
          acc = acc + 64'(dig_data) * pw;
          pw  = pw * 3;
          if (dig_last) begin
            if (word_q.size() != 0) check("value", acc, 64'(word_q.pop_front()));
            acc   = 0;
            pw    = 1;
            armed = bb_mode;
            gap   = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_outputs", 64'({dig_valid, dig_data, dig_idx, dig_last}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    // Directed words with hand-computed digits.
    send(32'd5, D_FIVE);
    drain();
    send(32'd0, D_ZERO);
    drain();
    send(32'hFFFF_FFFF, D_MAX);
    drain();
    send(32'd255, D_FF);
    drain();

    // Consumer stall at idx 2.
    rdy_mode = 2;
    send(32'h1234_5678, to_tern(32'h1234_5678));
    drain();
    rdy_mode = 0;

    // Reset in the middle of a word.
    send(32'h1234_5678, to_tern(32'h1234_5678));
    t = 0;
    while (!(dig_valid && dig_idx == 5'd7) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_idx7", 64'({dig_valid, dig_idx}), 64'({1'b1, 5'd7}));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({in_ready, dig_valid, dig_data, dig_idx, dig_last}), 64'd0);
    @(posedge clk);
    #1;
    check("held_reset_outputs", 64'({in_ready, dig_valid, dig_data, dig_idx, dig_last}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    word_q.delete();
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'({in_ready, dig_valid}), 64'({1'b1, 1'b0}));
    send(32'd255, D_FF);
    drain();

    // Back-to-back words with random downstream ready.
    bb_mode    = 1'b1;
    keep_valid = 1'b1;
    rdy_mode   = 1;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = (i % 4 == 0) ? 32'($urandom_range(0, 30)) : $urandom;
      send(w, to_tern(w));
    end
    keep_valid = 1'b0;
    in_valid   = 1'b0;
    drain();
    bb_mode  = 1'b0;
    rdy_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
